// File: rtl/vga_err_pkg.sv
// rtl/vga_err_pkg.sv - shared constants and helpers for the VGA error monitor
package vga_err_pkg;

    // Display-select offsets, each added to NUM_CH
    localparam int SEL_GRAND = 0;
    localparam int SEL_LAST  = 1;
    localparam int SEL_WORST = 2;
    localparam int SEL_ERRFR = 3;

    // Add two values and clamp the result to the all-ones value of a width-bit counter
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << width) - 33'd1;
        if (sum > max_val) begin
            return max_val[31:0];
        end
        return sum[31:0];
    endfunction

    // Number of set bits in an error vector of up to 8 channels
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/vga_err_sat_acc.sv
// rtl/vga_err_sat_acc.sv - saturating accumulator with load and clear
module vga_err_sat_acc
    import vga_err_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int INC_WIDTH = 2
) (
    input  logic                 pixel_clk,
    input  logic                 rst_n,
    input  logic [INC_WIDTH-1:0] inc,
    input  logic                 load,
    input  logic [INC_WIDTH-1:0] load_val,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] value
);

    // Clear wins over load, load wins over accumulate; accumulation never wraps
    always_ff @(posedge pixel_clk) begin
        if (!rst_n || clr) begin
            value <= '0;
        end else if (load) begin
            value <= CNT_WIDTH'(load_val);
        end else begin
            value <= CNT_WIDTH'(sat_add(32'(value), 32'(inc), CNT_WIDTH));
        end
    end

endmodule

// File: rtl/vga_error_monitor.sv
// rtl/vga_error_monitor.sv - multi-channel saturating VGA error statistics
module vga_error_monitor
    import vga_err_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 16,
    parameter int VSYNC_POL = 1,
    localparam int SEL_WIDTH = $clog2(NUM_CH + 4)
) (
    input  logic                 pixel_clk,
    input  logic                 rst_n,
    input  logic                 vsync,
    input  logic [NUM_CH-1:0]    err,
    input  logic                 clr,
    input  logic [SEL_WIDTH-1:0] sel,
    output logic [15:0]          disp,
    output logic [NUM_CH-1:0]    sticky,
    output logic                 any_err_frame
);

    localparam int   INC_WIDTH = $clog2(NUM_CH + 1);
    localparam logic VS_ACT    = (VSYNC_POL != 0);

    logic [CNT_WIDTH-1:0] ch_total [NUM_CH];
    logic [CNT_WIDTH-1:0] grand_total;
    logic [CNT_WIDTH-1:0] frame_acc;
    logic [CNT_WIDTH-1:0] last_frame;
    logic [CNT_WIDTH-1:0] worst_frame;
    logic [CNT_WIDTH-1:0] err_frames;
    logic                 vsync_q;
    logic                 armed;
    logic                 boundary;
    logic [INC_WIDTH-1:0] err_cnt;
    logic [15:0]          disp_nxt;

    function automatic logic [15:0] to16(input logic [CNT_WIDTH-1:0] x);
        logic [31:0] w;
        w = 32'(x);
        return w[15:0];
    endfunction

    // armed keeps a vsync level that is already active after reset/clr from
    // looking like a fresh edge on the first sampled cycle
    assign boundary = armed && (vsync == VS_ACT) && (vsync_q != VS_ACT);
    assign err_cnt  = INC_WIDTH'(popcount(8'(err)));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        vga_err_sat_acc #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_ch_acc (
            .pixel_clk (pixel_clk),
            .rst_n     (rst_n),
            .inc       (err[i]),
            .load      (1'b0),
            .load_val  (1'b0),
            .clr       (clr),
            .value     (ch_total[i])
        );
    end

    vga_err_sat_acc #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(INC_WIDTH)) u_grand_acc (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .inc       (err_cnt),
        .load      (1'b0),
        .load_val  ('0),
        .clr       (clr),
        .value     (grand_total)
    );

    // Boundary-cycle errors open the new frame, hence load rather than reset
    vga_err_sat_acc #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(INC_WIDTH)) u_frame_acc (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .inc       (err_cnt),
        .load      (boundary),
        .load_val  (err_cnt),
        .clr       (clr),
        .value     (frame_acc)
    );

    // Edge detect, sticky flags and the per-frame statistics latched at each boundary
    always_ff @(posedge pixel_clk) begin
        if (!rst_n || clr) begin
            vsync_q       <= 1'b0;
            armed         <= 1'b0;
            sticky        <= '0;
            any_err_frame <= 1'b0;
            last_frame    <= '0;
            worst_frame   <= '0;
            err_frames    <= '0;
        end else begin
            vsync_q       <= vsync;
            armed         <= 1'b1;
            sticky        <= sticky | err;
            any_err_frame <= boundary && (frame_acc != '0);
            if (boundary) begin
                last_frame <= frame_acc;
                if (frame_acc > worst_frame) begin
                    worst_frame <= frame_acc;
                end
                if (frame_acc != '0) begin
                    err_frames <= CNT_WIDTH'(sat_add(32'(err_frames), 32'd1, CNT_WIDTH));
                end
            end
        end
    end

    // Select the statistic to show; unused select codes read as zero
    always_comb begin
        int sel_i;
        disp_nxt = '0;
        sel_i    = 32'(sel);
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_i == i) begin
                disp_nxt = to16(ch_total[i]);
            end
        end
        if (sel_i == NUM_CH + SEL_GRAND) disp_nxt = to16(grand_total);
        if (sel_i == NUM_CH + SEL_LAST)  disp_nxt = to16(last_frame);
        if (sel_i == NUM_CH + SEL_WORST) disp_nxt = to16(worst_frame);
        if (sel_i == NUM_CH + SEL_ERRFR) disp_nxt = to16(err_frames);
    end

    // One register stage between the counters and the pmod pins
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            disp <= '0;
        end else begin
            disp <= disp_nxt;
        end
    end

endmodule

// File: tb/tb_vga_error_monitor.sv
// tb/tb_vga_error_monitor.sv - randomized self-checking bench for vga_error_monitor
module tb_vga_error_monitor;

    localparam int NUM_CH = 2;

    logic        pixel_clk;
    logic        rst_n;
    logic        vsync;
    logic [1:0]  err;
    logic        clr;
    logic [2:0]  sel;
    logic [15:0] disp16, disp8;
    logic [1:0]  sticky16, sticky8;
    logic        pulse16, pulse8;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: unbounded integer statistics, saturated only when compared
    int       m_ch [NUM_CH];
    int       m_grand, m_frame, m_last, m_worst, m_errfr;
    logic [1:0] m_sticky;
    logic     m_prev_active;
    logic     exp_pulse;

    vga_error_monitor #(.NUM_CH(NUM_CH), .CNT_WIDTH(16), .VSYNC_POL(1)) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .vsync(vsync), .err(err), .clr(clr),
        .sel(sel), .disp(disp16), .sticky(sticky16), .any_err_frame(pulse16)
    );

    vga_error_monitor #(.NUM_CH(NUM_CH), .CNT_WIDTH(8), .VSYNC_POL(1)) dut8 (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .vsync(vsync), .err(err), .clr(clr),
        .sel(sel), .disp(disp8), .sticky(sticky8), .any_err_frame(pulse8)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) m_ch[i] = 0;
        m_grand = 0; m_frame = 0; m_last = 0; m_worst = 0; m_errfr = 0;
        m_sticky = '0;
        m_prev_active = 1'b1;
        exp_pulse = 1'b0;
    endtask

    function automatic int exp_stat(input int s, input int w);
        int mx;
        int raw;
        mx = (1 << w) - 1;
        case (s)
            0: raw = m_ch[0];
            1: raw = m_ch[1];
            2: raw = m_grand;
            3: raw = m_last;
            4: raw = m_worst;
            5: raw = m_errfr;
            default: raw = 0;
        endcase
        if (raw > mx) raw = mx;
        return raw & 32'hFFFF;
    endfunction

    task automatic step(input logic [1:0] e, input logic v, input logic c);
        int pc;
        logic edge_seen;
        @(negedge pixel_clk);
        rst_n = 1'b1; err = e; vsync = v; clr = c;
        @(posedge pixel_clk);
        if (c) begin
            model_clear();
        end else begin
            pc = int'(e[0]) + int'(e[1]);
            edge_seen = v && !m_prev_active;
            for (int i = 0; i < NUM_CH; i++) m_ch[i] += int'(e[i]);
            m_grand += pc;
            m_sticky |= e;
            exp_pulse = 1'b0;
            if (edge_seen) begin
                m_last = m_frame;
                if (m_frame > m_worst) m_worst = m_frame;
                if (m_frame != 0) begin
                    m_errfr++;
                    exp_pulse = 1'b1;
                end
                m_frame = pc;
            end else begin
                m_frame += pc;
            end
            m_prev_active = v;
        end
        #1;
    endtask

    task automatic rd(input int s);
        sel = 3'(s);
        step(2'b00, vsync, 1'b0);
    endtask

    task automatic do_reset(input int cycles, input logic v);
        @(negedge pixel_clk);
        rst_n = 1'b0; err = '0; clr = 1'b0; vsync = v;
        repeat (cycles) @(posedge pixel_clk);
        #1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset(3, 1'b0);
        n_checks++; if ({disp16, disp8, sticky16, sticky8, pulse16, pulse8} !== '0)
            $display("FAIL reset_outputs: got %h required 0", {disp16, disp8, sticky16, sticky8, pulse16, pulse8});
        else n_pass++;
        for (int s = 0; s < 8; s++) begin
            rd(s);
            n_checks++; if (disp16 !== 16'd0 || disp8 !== 16'd0)
                $display("FAIL reset_disp sel=%0d: got %0d/%0d required 0", s, disp16, disp8);
            else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            step(2'b00, 1'b1, 1'b0);
            n_checks++; if (pulse16 !== 1'b0 || pulse8 !== 1'b0)
                $display("FAIL idle_pulse edge=%0d: got %b/%b required 0", k, pulse16, pulse8);
            else n_pass++;
            step(2'b00, 1'b1, 1'b0);
            step(2'b00, 1'b0, 1'b0);
        end
        n_checks++; if (sticky16 !== 2'b00) $display("FAIL idle_sticky: got %b required 00", sticky16);
        else n_pass++;
    endtask

    task automatic test_counts();
        step(2'b00, 1'b0, 1'b1);
        sel = 3'd2;
        repeat (5) step(2'b11, 1'b0, 1'b0);
        repeat (3) step(2'b01, 1'b0, 1'b0);
        n_checks++; if (disp16 !== 16'd12) $display("FAIL disp_latency_early: got %0d required 12", disp16);
        else n_pass++;
        step(2'b00, 1'b0, 1'b0);
        n_checks++; if (disp16 !== 16'd13) $display("FAIL disp_latency: got %0d required 13", disp16);
        else n_pass++;
        rd(0);
        n_checks++; if (disp16 !== 16'd8) $display("FAIL ch_total0: got %0d required 8", disp16);
        else n_pass++;
        rd(1);
        n_checks++; if (disp16 !== 16'd5) $display("FAIL ch_total1: got %0d required 5", disp16);
        else n_pass++;
        rd(2);
        n_checks++; if (disp8 !== 16'd13) $display("FAIL grand8: got %0d required 13", disp8);
        else n_pass++;
        n_checks++; if (sticky16 !== 2'b11) $display("FAIL sticky_set: got %b required 11", sticky16);
        else n_pass++;
    endtask

    task automatic frame(input int n, input logic [1:0] bnd_err, output logic p_bnd, output logic p_after);
        repeat (n) step(2'b01, 1'b0, 1'b0);
        step(bnd_err, 1'b1, 1'b0);
        p_bnd = pulse16;
        step(2'b00, 1'b1, 1'b0);
        p_after = pulse16;
        step(2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_frames();
        int counts [3] = '{4, 0, 7};
        logic req [3] = '{1'b1, 1'b0, 1'b1};
        logic pb, pa;
        step(2'b00, 1'b0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            frame(counts[f], 2'b00, pb, pa);
            n_checks++; if (pb !== req[f] || pa !== 1'b0)
                $display("FAIL frame_pulse f=%0d: got %b%b required %b0", f, pb, pa, req[f]);
            else n_pass++;
        end
        rd(3);
        n_checks++; if (disp16 !== 16'd7) $display("FAIL last_frame: got %0d required 7", disp16);
        else n_pass++;
        rd(4);
        n_checks++; if (disp16 !== 16'd7) $display("FAIL worst_frame: got %0d required 7", disp16);
        else n_pass++;
        rd(5);
        n_checks++; if (disp16 !== 16'd2) $display("FAIL err_frames: got %0d required 2", disp16);
        else n_pass++;
    endtask

    task automatic test_boundary_err();
        logic pb, pa;
        step(2'b00, 1'b0, 1'b1);
        frame(3, 2'b11, pb, pa);
        rd(3);
        n_checks++; if (disp16 !== 16'd3) $display("FAIL bnd_excl: got %0d required 3", disp16);
        else n_pass++;
        frame(4, 2'b00, pb, pa);
        rd(3);
        n_checks++; if (disp16 !== 16'd6) $display("FAIL bnd_incl: got %0d required 6", disp16);
        else n_pass++;
        rd(2);
        n_checks++; if (disp16 !== 16'd9) $display("FAIL bnd_grand: got %0d required 9", disp16);
        else n_pass++;
    endtask

    task automatic test_saturation();
        step(2'b00, 1'b0, 1'b1);
        repeat (300) step(2'b01, 1'b0, 1'b0);
        rd(0);
        n_checks++; if (disp8 !== 16'd255 || disp16 !== 16'd300)
            $display("FAIL sat_ch0: got %0d/%0d required 255/300", disp8, disp16);
        else n_pass++;
        rd(2);
        n_checks++; if (disp8 !== 16'd255) $display("FAIL sat_grand8: got %0d required 255", disp8);
        else n_pass++;
        step(2'b11, 1'b0, 1'b1);
        n_checks++; if (sticky16 !== 2'b00 || sticky8 !== 2'b00)
            $display("FAIL clr_sticky: got %b/%b required 00", sticky16, sticky8);
        else n_pass++;
        for (int s = 0; s < 6; s++) begin
            rd(s);
            n_checks++; if (disp16 !== 16'd0 || disp8 !== 16'd0)
                $display("FAIL clr_disp sel=%0d: got %0d/%0d required 0", s, disp16, disp8);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        step(2'b00, 1'b0, 1'b1);
        sel = 3'd2;
        repeat (9) step(2'b01, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        do_reset(1, 1'b1);
        n_checks++; if ({disp16, disp8, sticky16, sticky8, pulse16, pulse8} !== '0)
            $display("FAIL midframe_reset: got %h required 0", {disp16, disp8, sticky16, sticky8, pulse16, pulse8});
        else n_pass++;
        step(2'b01, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        n_checks++; if (pulse16 !== 1'b0) $display("FAIL held_vsync_pulse: got %b required 0", pulse16);
        else n_pass++;
        step(2'b00, 1'b0, 1'b0);
        rd(3);
        n_checks++; if (disp16 !== 16'(exp_stat(3, 16))) $display("FAIL held_vsync_last: got %0d required %0d", disp16, exp_stat(3, 16));
        else n_pass++;
    endtask

    task automatic test_random();
        logic v;
        int   vs_cnt;
        logic [1:0] e;
        logic c;
        v = 1'b0;
        vs_cnt = 10;
        for (int n = 0; n < 2000; n++) begin
            if (vs_cnt == 0) begin
                v = ~v;
                vs_cnt = $urandom_range(2, 40);
            end else begin
                vs_cnt--;
            end
            e = 2'($urandom_range(0, 3));
            c = ($urandom_range(0, 299) == 0);
            step(e, v, c);
            n_checks++; if (pulse16 !== exp_pulse || pulse8 !== exp_pulse || sticky16 !== m_sticky || sticky8 !== m_sticky)
                $display("FAIL rand_flags n=%0d: got %b%b %b %b required %b %b", n, pulse16, pulse8, sticky16, sticky8, exp_pulse, m_sticky);
            else n_pass++;
            if (n % 100 == 99) begin
                for (int s = 0; s < 8; s++) begin
                    rd(s);
                    n_checks++; if (disp16 !== 16'(exp_stat(s, 16)) || disp8 !== 16'(exp_stat(s, 8)))
                        $display("FAIL rand_disp n=%0d sel=%0d: got %0d/%0d required %0d/%0d", n, s, disp16, disp8, exp_stat(s, 16), exp_stat(s, 8));
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; vsync = 1'b0; err = '0; clr = 1'b0; sel = '0;
        model_clear();
        test_reset();
        test_counts();
        test_frames();
        test_boundary_err();
        test_saturation();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_error_monitor.md
# vga_error_monitor

Multi-channel VGA error monitor in the pixel clock domain. It replaces the single ad-hoc 16-bit error counter in the striped-SRAM pattern demo tops. It takes one error strobe per stripe/SRAM channel plus vsync and keeps saturating lifetime and per-frame statistics. A registered, selectable 16-bit view drives two debug pmods; sticky per-channel flags drive LEDs.

## Interface
- NUM_CH, 2: number of error channels (1..8).
- CNT_WIDTH, 16: width of every counter (8..32).
- VSYNC_POL, 1: active level of vsync (1 for 800x600@60).
- SEL_WIDTH, localparam: $clog2(NUM_CH+4).
- pixel_clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- vsync  in  1  VGA vsync, same cycle alignment as the video output.
- err  in  NUM_CH  per-channel error strobe; one count per asserted bit per cycle.
- clr  in  1  synchronous clear of all statistics.
- sel  in  SEL_WIDTH  display select.
- disp  out  16  selected statistic, registered.
- sticky  out  NUM_CH  bit set once that channel has errored since reset/clr.
- any_err_frame  out  1  one-cycle pulse at a frame boundary if the just-closed frame had ≥1 error.

## Operation
- Counters, all CNT_WIDTH and saturating at all-ones (never wrap):
  - ch_total[i]: lifetime errors on channel i.
  - grand_total: lifetime errors, all channels.
  - frame_acc: errors in the current frame.
  - last_frame: frame_acc of the previous frame.
  - worst_frame: max last_frame seen.
  - err_frames: count of frames with ≥1 error.
- Per cycle, grand_total and frame_acc add popcount(err) (0..NUM_CH). The sum saturates; it does not wrap.
- Frame boundary: cycle where vsync==VSYNC_POL and vsync_q!=VSYNC_POL (vsync_q is vsync registered). On that cycle:
  - last_frame ← frame_acc.
  - worst_frame ← max(worst_frame, frame_acc).
  - err_frames increments if frame_acc≠0.
  - any_err_frame pulses.
  - frame_acc ← popcount(err) of that cycle. Boundary-cycle errors belong to the new frame.
- The first frame after reset/clr is partial. It is still latched at the first boundary.
- clr has priority over err and the boundary in the same cycle. All counters, sticky, vsync_q and any_err_frame go to 0. That cycle's err is discarded.
- sel encoding:
  - 0..NUM_CH-1 → ch_total[sel].
  - NUM_CH → grand_total.
  - NUM_CH+1 → last_frame.
  - NUM_CH+2 → worst_frame.
  - NUM_CH+3 → err_frames.
  - Any other value → 0.
- Values are zero-extended to 16 bits, or truncated to the low 16 bits if CNT_WIDTH>16.

## Timing
- Reset values: every counter 0, disp=0, sticky=0, any_err_frame=0, vsync_q=0.
- rst_n low mid-frame discards frame_acc. A boundary is then detected only on a fresh vsync edge after reset; vsync already active at reset release does not count.
- err sampled at cycle N:
  - counters and sticky updated at N+1;
  - disp reflects it at N+2 (one register stage after the counters).
- sel change at cycle N → disp reflects it at N+1.
- Boundary detected at cycle N (vsync edge at N) → last_frame, worst_frame and err_frames valid at N+1; any_err_frame high during N+1 only.
- No handshakes. Inputs must already be synchronous to pixel_clk.

## Structure
- Package vga_err_pkg:
  - sel offset constants SEL_GRAND=0, SEL_LAST=1, SEL_WORST=2, SEL_ERRFR=3, each added to NUM_CH;
  - function sat_add(a, b, width).
- Sub-module vga_err_sat_acc: a CNT_WIDTH saturating accumulator with inputs inc (0..NUM_CH), load, load_val, clr.
  - Instantiated NUM_CH times for ch_total, once for grand_total, once for frame_acc (uses load at boundary).
  - worst_frame and err_frames are written inline.
- Popcount is a combinational function in the package.

## Test plan
- Reset, then idle: disp=0 for every sel, sticky=0, no any_err_frame pulse across 3 vsync edges.
- NUM_CH=2: err=2'b11 for 5 cycles, then err=2'b01 for 3 cycles, no vsync edge:
  - ch_total[0]=8, ch_total[1]=5, grand_total=13;
  - disp with sel=2 reads 13 two cycles after the last err.
- Frames with error counts 4, 0, 7:
  - after the 3rd boundary: last_frame=7, worst_frame=7, err_frames=2;
  - any_err_frame pulses at boundaries 1 and 3 only.
- Boundary-cycle err=2'b11: last_frame excludes those 2; the next boundary's last_frame includes them.
- CNT_WIDTH=8: 300 cycles of err=2'b01 → ch_total[0]=255 with no wrap. Then clr asserted together with err=2'b11 → every counter 0 next cycle and sticky=0.
- sel=NUM_CH+4 (out of range) → disp=0. Assert rst_n low mid-frame with frame_acc=9 → all outputs 0 the next cycle.
